alu_sequencer: RTL and testbench

- Single-issue sequencer that accepts one ALU instruction at a time (8-bit mnemonic plus 2-bit destination register) over a valid/ready handshake.
- Drives the mnemonic into ALU_Control and classifies the op as fixed-latency or multi-cycle (MUL/DIV).
- Waits for the result, bounding multi-cycle ops with a timeout, and issues one write to register a..d.
- Sits between instruction fetch/decode and the ALU_Control/ALU/register-file datapath.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_op_classify.sv | 36 +++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer.
//   state_e      : sequencer FSM state encoding
//   GRP_*        : mnemonic group field values (mnemonic[7:4])
//   REG_*        : register-file destination codes
//   CNT_BITS     : width of the EXEC cycle counter (covers TIMEOUT up to 255)
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic [3:0] GRP_ADDSUB = 4'b1000;
    localparam logic [3:0] GRP_MULDIV = 4'b1001;
    localparam logic [3:0] GRP_BIT0   = 4'b1010;
    localparam logic [3:0] GRP_BIT1   = 4'b1011;
    localparam logic [3:0] GRP_UNARY  = 4'b1100;

    // Op field value with no unary operation behind it
    localparam logic [1:0] UNARY_OP_RSVD = 2'b11;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    localparam int unsigned CNT_BITS = 8;

endpackage

// File: rtl/alu_op_classify.sv
// Combinational mnemonic classifier.
//   mnemonic    in  8 : [7:4] group, [3:2] op, [1:0] operand select
//   legal       out 1 : mnemonic names an implemented operation
//   multi_cycle out 1 : operation completes on alu_done rather than after a fixed latency
module alu_op_classify
    import alu_seq_pkg::*;
(
    input  logic [7:0] mnemonic,
    output logic       legal,
    output logic       multi_cycle
);

    logic [3:0] grp;
    logic [1:0] op;
    logic       unused_opsel;

    assign grp = mnemonic[7:4];
    assign op  = mnemonic[3:2];
    // Operand select does not affect legality or latency
    assign unused_opsel = ^mnemonic[1:0];

    always_comb begin
        legal       = 1'b0;
        multi_cycle = 1'b0;
        case (grp)
            GRP_ADDSUB, GRP_BIT0, GRP_BIT1: legal = 1'b1;
            GRP_MULDIV: begin
                legal       = 1'b1;
                multi_cycle = 1'b1;
            end
            GRP_UNARY: legal = (op != UNARY_OP_RSVD);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue ALU instruction sequencer: accepts one instruction over valid/ready,
// drives the mnemonic to ALU_Control, waits for the result (fixed latency or
// alu_done with timeout) and issues one register-file write.
//   clk, rst_n              : clock, asynchronous active-low reset
//   instr_valid/ready       : instruction handshake (ready is decoded from state only)
//   instr_mnem, instr_dst   : mnemonic and destination register
//   alu_mnemonic, alu_start : to ALU_Control; start pulses once for MUL/DIV
//   alu_done, alu_result    : from ALU
//   wr_en, wr_addr, wr_data : register-file write port
//   busy, err_illegal, err_timeout, retire_count : status
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr_mnem,
    input  logic [1:0]       instr_dst,
    output logic [7:0]       alu_mnemonic,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [31:0]      alu_result,
    output logic             wr_en,
    output logic [1:0]       wr_addr,
    output logic [31:0]      wr_data,
    output logic             busy,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [CNT_BITS-1:0] LAT_LAST = CNT_BITS'(ALU_LAT - 1);
    localparam logic [CNT_BITS-1:0] TO_LAST  = CNT_BITS'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [7:0]          mnem_q, mnem_d;
    logic [1:0]          dst_q, dst_d;
    logic                multi_q, multi_d;
    logic [31:0]         result_q, result_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]    retire_q, retire_d;

    logic in_legal;
    logic in_multi;

    alu_op_classify u_classify (
        .mnemonic    (instr_mnem),
        .legal       (in_legal),
        .multi_cycle (in_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mnem_q        <= '0;
            dst_q         <= '0;
            multi_q       <= 1'b0;
            result_q      <= '0;
            cnt_q         <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            retire_q      <= '0;
        end else begin
            state_q       <= state_d;
            mnem_q        <= mnem_d;
            dst_q         <= dst_d;
            multi_q       <= multi_d;
            result_q      <= result_d;
            cnt_q         <= cnt_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
            retire_q      <= retire_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mnem_d        = mnem_q;
        dst_d         = dst_q;
        multi_d       = multi_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;
        retire_d      = retire_q;

        case (state_q)
            IDLE: begin
                // instr_ready is 1 throughout IDLE, so valid alone completes the handshake
                if (instr_valid) begin
                    if (in_legal) begin
                        mnem_d  = instr_mnem;
                        dst_d   = instr_dst;
                        multi_d = in_multi;
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (multi_q) begin
                    // alu_done takes priority over a coincident timeout
                    if (alu_done) begin
                        result_d = alu_result;
                        state_d  = WB;
                    end else if (cnt_q == TO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == LAT_LAST) begin
                    result_d = alu_result;
                    state_d  = WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                retire_d = retire_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign alu_mnemonic = (state_q == IDLE) ? 8'h00 : mnem_q;
    // cnt_q is zero only in the first EXEC cycle
    assign alu_start    = (state_q == EXEC) && multi_q && (cnt_q == '0);
    assign wr_en        = (state_q == WB);
    assign wr_addr      = wr_en ? dst_q : 2'd0;
    assign wr_data      = wr_en ? result_q : 32'd0;
    assign err_illegal  = err_illegal_q;
    assign err_timeout  = err_timeout_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  instr_mnem = 8'h00;
    logic [1:0]  instr_dst = 2'd0;
    logic [7:0]  alu_mnemonic;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        err_illegal;
    logic        err_timeout;
    logic [15:0] retire_count;

    alu_sequencer #(
        .ALU_LAT (1),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_mnem   (instr_mnem),
        .instr_dst    (instr_dst),
        .alu_mnemonic (alu_mnemonic),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .err_illegal  (err_illegal),
        .err_timeout  (err_timeout),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  wr_cycles[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard: every write must match the oldest outstanding expectation
    always @(negedge clk) begin : sb_monitor
        wr_t exp_wr;
        if (wr_en === 1'b1) begin
            checks++;
            wr_cycles.push_back(cycle);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h expected no write",
                         wr_addr, wr_data);
            end else begin
                exp_wr = sb.pop_front();
                if ({wr_addr, wr_data} !== exp_wr) begin
                    errors++;
                    $display("FAIL write_data got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        alu_done    = 1'b0;
        repeat (2) @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        alu_done    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({instr_ready, busy, wr_en, alu_start, err_illegal, err_timeout} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 100000",
                     {instr_ready, busy, wr_en, alu_start, err_illegal, err_timeout});
        end
        checks++;
        if ({alu_mnemonic, wr_addr, wr_data, retire_count} !== 58'd0) begin
            errors++;
            $display("FAIL reset_buses got mnem=%h addr=%0d data=%h retire=%0d expected zeros",
                     alu_mnemonic, wr_addr, wr_data, retire_count);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        step();
        instr_valid = 1'b1;
        instr_mnem  = 8'h81;
        instr_dst   = REG_C;
        alu_result  = 32'h0000_0007;
        sb.push_back({REG_C, 32'h0000_0007});
        step();                     // handshake edge passed: EXEC
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready, busy, alu_mnemonic} !== {2'b01, 8'h81}) begin
            errors++;
            $display("FAIL add_exec got ready=%b busy=%b mnem=%h expected ready=0 busy=1 mnem=81",
                     instr_ready, busy, alu_mnemonic);
        end
        step();                     // WB
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL add_wr_en got %b expected 1", wr_en);
        end
        step();                     // IDLE again
        @(negedge clk);
        checks++;
        if ({instr_ready, wr_en, retire_count} !== {2'b10, 16'd1}) begin
            errors++;
            $display("FAIL add_retire got ready=%b wr_en=%b retire=%0d expected ready=1 wr_en=0 retire=1",
                     instr_ready, wr_en, retire_count);
        end
    endtask

    task automatic test_mul;
        int   starts;
        logic busy_bad;
        starts   = 0;
        busy_bad = 1'b0;
        step();
        instr_valid = 1'b1;
        instr_mnem  = 8'h91;
        instr_dst   = REG_A;
        alu_result  = 32'h0;
        sb.push_back({REG_A, 32'h0000_0C00});
        step();                     // first EXEC cycle: alu_start expected
        instr_valid = 1'b0;
        @(negedge clk);
        if (alu_start) starts++;
        if (!busy) busy_bad = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            if (alu_start) starts++;
            if (!busy) busy_bad = 1'b1;
        end
        step();                     // 5 cycles after alu_start
        alu_done   = 1'b1;
        alu_result = 32'h0000_0C00;
        @(negedge clk);
        if (alu_start) starts++;
        if (!busy) busy_bad = 1'b1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mul_early_write got wr_en=%b expected 0", wr_en);
        end
        step();
        alu_done   = 1'b0;
        alu_result = 32'h0;
        @(negedge clk);
        checks++;
        if ({wr_en, busy, alu_mnemonic} !== {2'b11, 8'h91}) begin
            errors++;
            $display("FAIL mul_wb got wr_en=%b busy=%b mnem=%h expected wr_en=1 busy=1 mnem=91",
                     wr_en, busy, alu_mnemonic);
        end
        step();
        @(negedge clk);
        checks++;
        if (starts != 1 || busy_bad) begin
            errors++;
            $display("FAIL mul_start_busy got starts=%0d busy_drop=%b expected starts=1 busy_drop=0",
                     starts, busy_bad);
        end
        checks++;
        if ({instr_ready, retire_count} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL mul_retire got ready=%b retire=%0d expected ready=1 retire=2",
                     instr_ready, retire_count);
        end
    endtask

    task automatic test_timeout;
        logic bad;
        bad = 1'b0;
        step();
        instr_valid = 1'b1;
        instr_mnem  = 8'h95;
        instr_dst   = REG_D;
        step();                     // first EXEC cycle
        instr_valid = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            if (!busy || err_timeout) bad = 1'b1;
            step();
        end
        @(negedge clk);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL timeout_exec got early exit or pulse expected %0d busy cycles", TIMEOUT);
        end
        checks++;
        if ({err_timeout, instr_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_pulse got err=%b ready=%b busy=%b expected err=1 ready=1 busy=0",
                     err_timeout, instr_ready, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if ({err_timeout, retire_count} !== {1'b0, 16'd2}) begin
            errors++;
            $display("FAIL timeout_after got err=%b retire=%0d expected err=0 retire=2",
                     err_timeout, retire_count);
        end
    endtask

    task automatic test_illegal;
        logic [7:0] codes [2];
        codes[0] = 8'h20;
        codes[1] = 8'hCC;
        for (int k = 0; k < 2; k++) begin
            step();
            instr_valid = 1'b1;
            instr_mnem  = codes[k];
            instr_dst   = REG_B;
            step();
            instr_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({err_illegal, instr_ready, busy} !== 3'b110) begin
                errors++;
                $display("FAIL illegal_pulse mnem=%h got err=%b ready=%b busy=%b expected 1 1 0",
                         codes[k], err_illegal, instr_ready, busy);
            end
            step();
            @(negedge clk);
            checks++;
            if ({err_illegal, retire_count} !== {1'b0, 16'd2}) begin
                errors++;
                $display("FAIL illegal_after mnem=%h got err=%b retire=%0d expected err=0 retire=2",
                         codes[k], err_illegal, retire_count);
            end
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        wr_cycles.delete();
        step();
        instr_valid = 1'b1;
        instr_mnem  = 8'hB0;
        instr_dst   = REG_B;
        alu_result  = 32'h1111_1111;
        sb.push_back({REG_B, 32'h1111_1111});
        sb.push_back({REG_D, 32'h2222_2222});
        step();                     // XOR in EXEC, valid stays high
        instr_mnem = 8'hC0;
        instr_dst  = REG_D;
        @(negedge clk);
        checks++;
        if (alu_mnemonic !== 8'hB0) begin
            errors++;
            $display("FAIL b2b_hold got mnem=%h expected b0", alu_mnemonic);
        end
        step();                     // XOR in WB
        alu_result = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_wb got %b expected 0", instr_ready);
        end
        step();                     // IDLE: NEG accepted at the end of this cycle
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_idle got %b expected 1", instr_ready);
        end
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_mnemonic !== 8'hC0) begin
            errors++;
            $display("FAIL b2b_second got mnem=%h expected c0", alu_mnemonic);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (wr_cycles.size() != 2 || (wr_cycles[1] - wr_cycles[0]) != 3) begin
            errors++;
            $display("FAIL b2b_spacing got writes=%0d gap=%0d expected writes=2 gap=3",
                     wr_cycles.size(),
                     (wr_cycles.size() == 2) ? (wr_cycles[1] - wr_cycles[0]) : -1);
        end
        checks++;
        if (retire_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_retire got %0d expected 2", retire_count);
        end
    endtask

    task automatic test_reset_mid_op;
        logic bad;
        bad = 1'b0;
        step();
        instr_valid = 1'b1;
        instr_mnem  = 8'h92;
        instr_dst   = REG_B;
        step();
        instr_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready, busy, wr_en, alu_start, err_illegal, err_timeout, alu_mnemonic,
             retire_count} !== {6'b100000, 8'h00, 16'd0}) begin
            errors++;
            $display("FAIL midop_reset got ready=%b busy=%b wr=%b mnem=%h retire=%0d expected reset values",
                     instr_ready, busy, wr_en, alu_mnemonic, retire_count);
        end
        step();
        rst_n = 1'b1;
        step();
        alu_done   = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        step();
        alu_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_en || busy || err_illegal || err_timeout || !instr_ready) bad = 1'b1;
            step();
        end
        checks++;
        if (bad || retire_count !== 16'd0) begin
            errors++;
            $display("FAIL midop_late_done got activity=%b retire=%0d expected activity=0 retire=0",
                     bad, retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending writes expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
